result_serializer: RTL and testbench

- Downstream stage of the systolic accelerator top.
- Consumes the paired fixed-point result stream (two results per transfer, upper half first) and buffers it in a small FIFO.
- Serializes each pair into single-element transfers, each tagged with its element index within the SYSTOLIC_SIZE x SYSTOLIC_SIZE output tile and a last-of-tile flag.
- Lets a narrow host or test interface drain results without ever back-pressuring mid-pair.

---
 rtl/result_serializer_pkg.sv | 37 +++
 rtl/result_fifo.sv | 81 ++++++++
 rtl/result_serializer.sv | 134 +++++++++++++
 tb/tb_result_serializer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_serializer_pkg.sv
// Shared types and constants for the result serializer slice.
package result_serializer_pkg;

   localparam int DEF_INT_WIDTH     = 8;
   localparam int DEF_FRAC_WIDTH    = 8;
   localparam int DEF_SYSTOLIC_SIZE = 4;
   localparam int DEF_BUF_ENTRIES   = 2;

   localparam int DATA_W = DEF_INT_WIDTH + DEF_FRAC_WIDTH;
   localparam int IDX_W  = $clog2(DEF_SYSTOLIC_SIZE * DEF_SYSTOLIC_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } ser_state_t;

   // One serialized element as it appears on send_msg.
   typedef struct packed {
      logic              last;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } ser_msg_t;

   // Advance the in-tile element index, wrapping after the final element.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] last_idx);
      logic [IDX_W-1:0] nxt;
      if (idx == last_idx) begin
         nxt = {IDX_W{1'b0}};
      end else begin
         nxt = idx + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular pair buffer with registered storage, registered handshake flags
// and no bypass: data pushed this cycle is visible on the output next cycle.
module result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_msg,
   output logic             empty_next
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
   logic [CNT_W-1:0] count_r, count_next_s;
   logic             in_rdy_r, out_val_r, push_s, pop_s;

   // Handshake decode and next pointer / occupancy computation.
   always_comb begin
      push_s        = in_val && in_rdy_r;
      pop_s         = out_rdy && out_val_r;
      wr_ptr_next_s = wr_ptr_r;
      rd_ptr_next_s = rd_ptr_r;
      count_next_s  = count_r;
      if (push_s) begin
         wr_ptr_next_s = (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_next_s = (rd_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         2'b01:   count_next_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
         default: count_next_s = count_r;
      endcase
      empty_next = (count_next_s == {CNT_W{1'b0}});
   end

   // Pointer, occupancy and registered flag state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r  <= {PTR_W{1'b0}};
         rd_ptr_r  <= {PTR_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         in_rdy_r  <= 1'b0;
         out_val_r <= 1'b0;
      end else begin
         wr_ptr_r  <= wr_ptr_next_s;
         rd_ptr_r  <= rd_ptr_next_s;
         count_r   <= count_next_s;
         in_rdy_r  <= (count_next_s != FULL_CNT);
         out_val_r <= (count_next_s != {CNT_W{1'b0}});
      end
   end

   // Storage write; contents are don't-care until the slot is marked valid.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_msg;
      end
   end

   assign in_rdy  = in_rdy_r;
   assign out_val = out_val_r;
   assign out_msg = mem_r[rd_ptr_r];

endmodule

// File: rtl/result_serializer.sv
// Splits buffered result pairs into single tagged elements (upper half first),
// numbering them within the output tile and flagging the tile's last element.
// Widths of the message struct come from the package, so parameter overrides
// must be mirrored there.
module result_serializer
   import result_serializer_pkg::*;
#(
   parameter int INT_WIDTH     = DEF_INT_WIDTH,
   parameter int FRAC_WIDTH    = DEF_FRAC_WIDTH,
   parameter int SYSTOLIC_SIZE = DEF_SYSTOLIC_SIZE,
   parameter int BUF_ENTRIES   = DEF_BUF_ENTRIES
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic                                                   recv_val,
   output logic                                                   recv_rdy,
   input  logic [2*(INT_WIDTH+FRAC_WIDTH)-1:0]                    recv_msg,
   output logic                                                   send_val,
   input  logic                                                   send_rdy,
   output logic [INT_WIDTH+FRAC_WIDTH+$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE):0] send_msg,
   output logic                                                   busy
);

   localparam int W = INT_WIDTH + FRAC_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYSTOLIC_SIZE * SYSTOLIC_SIZE - 1);

   ser_state_t       state_r, state_next_s;
   logic [2*W-1:0]   hold_r, hold_next_s;
   logic [IDX_W-1:0] idx_r, idx_next_s;
   logic             send_val_r, busy_r;
   ser_msg_t         msg_r, msg_next_s;

   logic             fifo_val_s, fifo_empty_next_s, pop_s;
   logic [2*W-1:0]   fifo_msg_s;

   result_fifo #(
      .WIDTH (2 * W),
      .DEPTH (BUF_ENTRIES)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .in_val     (recv_val),
      .in_rdy     (recv_rdy),
      .in_msg     (recv_msg),
      .out_val    (fifo_val_s),
      .out_rdy    (pop_s),
      .out_msg    (fifo_msg_s),
      .empty_next (fifo_empty_next_s)
   );

   // Serializer next state, hold-register load, index advance and next output message.
   always_comb begin
      state_next_s = state_r;
      hold_next_s  = hold_r;
      idx_next_s   = idx_r;
      pop_s        = 1'b0;
      msg_next_s   = '0;
      case (state_r)
         IDLE: begin
            if (fifo_val_s) begin
               pop_s        = 1'b1;
               hold_next_s  = fifo_msg_s;
               state_next_s = HI;
            end else begin
               state_next_s = IDLE;
            end
         end
         HI: begin
            if (send_rdy) begin
               idx_next_s   = next_idx(idx_r, LAST_IDX);
               state_next_s = LO;
            end else begin
               state_next_s = HI;
            end
         end
         LO: begin
            if (send_rdy) begin
               idx_next_s = next_idx(idx_r, LAST_IDX);
               if (fifo_val_s) begin
                  pop_s        = 1'b1;
                  hold_next_s  = fifo_msg_s;
                  state_next_s = HI;
               end else begin
                  state_next_s = IDLE;
               end
            end else begin
               state_next_s = LO;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
      case (state_next_s)
         HI: begin
            msg_next_s.data = hold_next_s[2*W-1:W];
            msg_next_s.idx  = idx_next_s;
            msg_next_s.last = (idx_next_s == LAST_IDX);
         end
         LO: begin
            msg_next_s.data = hold_next_s[W-1:0];
            msg_next_s.idx  = idx_next_s;
            msg_next_s.last = (idx_next_s == LAST_IDX);
         end
         default: begin
            msg_next_s = '0;
         end
      endcase
   end

   // Serializer state and registered output stage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         hold_r     <= {(2*W){1'b0}};
         idx_r      <= {IDX_W{1'b0}};
         send_val_r <= 1'b0;
         msg_r      <= '0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         hold_r     <= hold_next_s;
         idx_r      <= idx_next_s;
         send_val_r <= (state_next_s != IDLE);
         msg_r      <= msg_next_s;
         busy_r     <= (!fifo_empty_next_s) || (state_next_s != IDLE);
      end
   end

   assign send_val = send_val_r;
   assign send_msg = msg_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_result_serializer.sv
// Randomized self-checking bench for result_serializer; a queue of expected
// elements plus a modulo tile counter serves as the reference model.
module tb_result_serializer;

   localparam int W    = 16;
   localparam int IW   = 4;
   localparam int MW   = W + IW + 1;
   localparam int TILE = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            recv_val;
   logic            recv_rdy;
   logic [2*W-1:0]  recv_msg;
   logic            send_val;
   logic            send_rdy;
   logic [MW-1:0]   send_msg;
   logic            busy;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] exp_q[$];
   int           exp_idx = 0;

   always #5 clk = ~clk;

   result_serializer dut (
      .clk      (clk),
      .reset    (reset),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .recv_msg (recv_msg),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .send_msg (send_msg),
      .busy     (busy)
   );

   // Next expected element: data from the queue, index = handshake count mod tile size.
   function automatic logic [MW-1:0] pop_expected();
      logic [W-1:0]  d;
      logic [IW-1:0] i;
      logic          l;
      if (exp_q.size() == 0) begin
         d = '1;
      end else begin
         d = exp_q.pop_front();
      end
      i = IW'(exp_idx);
      l = (exp_idx == TILE - 1);
      exp_idx = (exp_idx + 1) % TILE;
      return {l, i, d};
   endfunction

   // Inputs are set at the negedge; record handshakes, then advance one cycle.
   task automatic tick(output logic in_hs, output logic out_hs, output logic [MW-1:0] seen);
      #1;
      in_hs  = recv_val && recv_rdy;
      out_hs = send_val && send_rdy;
      seen   = send_msg;
      if (in_hs) begin
         exp_q.push_back(recv_msg[2*W-1:W]);
         exp_q.push_back(recv_msg[W-1:0]);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b0;
      recv_val = 1'b0;
      send_rdy = 1'b0;
      recv_msg = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      exp_idx = 0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic ih, oh;
      logic [MW-1:0] s;
      @(negedge clk);
      reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b0; recv_msg = '0;
      repeat (3) @(negedge clk);
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL rst_send_val got %b want 0", send_val); end
      checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL rst_recv_rdy got %b want 0", recv_rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (send_msg !== '0) begin errors++; $display("FAIL rst_send_msg got %h want 0", send_msg); end
      reset = 1'b1;
      exp_q.delete(); exp_idx = 0;
      @(negedge clk);
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL idle_recv_rdy got %b want 1", recv_rdy); end
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL idle_send_val got %b want 0", send_val); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
      // Reset in the middle of a pair must drop send_val without a clock edge.
      recv_val = 1'b1; recv_msg = $urandom;
      tick(ih, oh, s);
      recv_val = 1'b0;
      tick(ih, oh, s);
      checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL mid_pre_val got %b want 1", send_val); end
      reset = 1'b0;
      #1;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL mid_async_val got %b want 0", send_val); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %b want 0", busy); end
      do_reset();
   endtask

   task automatic test_single_pair();
      logic ih, oh;
      logic [MW-1:0] s;
      do_reset();
      recv_msg = 32'h0102_0304; recv_val = 1'b1;
      tick(ih, oh, s);
      checks++; if (ih !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", ih); end
      recv_val = 1'b0; send_rdy = 1'b1;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL single_lat1 got %b want 0", send_val); end
      tick(ih, oh, s);
      checks++; if (send_val !== 1'b1 || send_msg !== {1'b0, 4'd0, 16'h0102})
         begin errors++; $display("FAIL single_hi got val=%b msg=%h want val=1 msg=%h", send_val, send_msg, {1'b0, 4'd0, 16'h0102}); end
      tick(ih, oh, s);
      checks++; if (send_val !== 1'b1 || send_msg !== {1'b0, 4'd1, 16'h0304})
         begin errors++; $display("FAIL single_lo got val=%b msg=%h want val=1 msg=%h", send_val, send_msg, {1'b0, 4'd1, 16'h0304}); end
      tick(ih, oh, s);
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL single_end got %b want 0", send_val); end
   endtask

   task automatic test_full_tile();
      logic ih, oh;
      logic [MW-1:0] s, e;
      int pushes = 0, outs = 0, bubbles = 0, lasts = 0;
      logic started = 1'b0;
      do_reset();
      send_rdy = 1'b1;
      for (int c = 0; c < 100 && outs < 18; c++) begin
         recv_val = (pushes < 9);
         recv_msg = $urandom;
         tick(ih, oh, s);
         if (ih) pushes++;
         if (oh) begin
            e = pop_expected();
            checks++; if (s !== e) begin errors++; $display("FAIL tile_elem%0d got %h want %h", outs, s, e); end
            if (s[MW-1]) lasts++;
            outs++;
            started = 1'b1;
         end else if (started) begin
            bubbles++;
         end
      end
      recv_val = 1'b0;
      checks++; if (outs != 18) begin errors++; $display("FAIL tile_count got %0d want 18", outs); end
      checks++; if (bubbles != 0) begin errors++; $display("FAIL tile_bubbles got %0d want 0", bubbles); end
      checks++; if (lasts != 1) begin errors++; $display("FAIL tile_lasts got %0d want 1", lasts); end
   endtask

   task automatic test_backpressure();
      logic ih, oh;
      logic [MW-1:0] s, e, held;
      int acc = 0, outs = 0, unstable = 0;
      logic have = 1'b0;
      do_reset();
      send_rdy = 1'b0; recv_val = 1'b1;
      for (int c = 0; c < 12; c++) begin
         recv_msg = $urandom;
         tick(ih, oh, s);
         if (ih) acc++;
         if (send_val) begin
            if (!have) begin held = send_msg; have = 1'b1; end
            else if (send_msg !== held) unstable++;
         end
      end
      checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted got %0d want 3", acc); end
      checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL bp_recv_rdy got %b want 0", recv_rdy); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b want 1", busy); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", unstable); end
      recv_val = 1'b0; send_rdy = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick(ih, oh, s);
         if (oh) begin
            e = pop_expected();
            checks++; if (s !== e) begin errors++; $display("FAIL bp_elem%0d got %h want %h", outs, s, e); end
            outs++;
         end
      end
      checks++; if (outs != 6) begin errors++; $display("FAIL bp_drain got %0d want 6", outs); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_random();
      logic ih, oh, sv, prev_stall;
      logic [MW-1:0] s, e, prev_msg;
      int acc = 0, outs = 0, unstable = 0;
      do_reset();
      prev_stall = 1'b0; prev_msg = '0;
      for (int c = 0; c < 20000 && (acc < 1000 || exp_q.size() != 0); c++) begin
         recv_val = (acc < 1000) && ($urandom_range(9, 0) < 7);
         recv_msg = $urandom;
         send_rdy = ($urandom_range(9, 0) < 6);
         if (prev_stall && (send_val !== 1'b1 || send_msg !== prev_msg)) unstable++;
         sv = send_val;
         tick(ih, oh, s);
         prev_stall = sv && !oh;
         prev_msg   = s;
         if (ih) acc++;
         if (oh) begin
            e = pop_expected();
            checks++; if (s !== e) begin errors++; $display("FAIL rnd_elem%0d got %h want %h", outs, s, e); end
            outs++;
         end
      end
      send_rdy = 1'b0; recv_val = 1'b0;
      checks++; if (acc != 1000) begin errors++; $display("FAIL rnd_accepted got %0d want 1000", acc); end
      checks++; if (outs != 2000) begin errors++; $display("FAIL rnd_outputs got %0d want 2000", outs); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL rnd_stable got %0d want 0", unstable); end
   endtask

   task automatic test_full_collision();
      logic ih, oh;
      logic [MW-1:0] s, e;
      int acc = 0;
      do_reset();
      send_rdy = 1'b0; recv_val = 1'b1;
      for (int c = 0; c < 10 && recv_rdy; c++) begin
         recv_msg = $urandom;
         tick(ih, oh, s);
         if (ih) acc++;
      end
      checks++; if (acc != 3) begin errors++; $display("FAIL col_fill got %0d want 3", acc); end
      recv_val = 1'b0; send_rdy = 1'b1;
      tick(ih, oh, s);
      if (oh) begin
         e = pop_expected();
         checks++; if (s !== e) begin errors++; $display("FAIL col_hi got %h want %h", s, e); end
      end
      send_rdy = 1'b0;
      tick(ih, oh, s);
      checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL col_full_rdy got %b want 0", recv_rdy); end
      recv_val = 1'b1; send_rdy = 1'b1; recv_msg = $urandom;
      tick(ih, oh, s);
      checks++; if (ih !== 1'b0) begin errors++; $display("FAIL col_push got %b want 0", ih); end
      checks++; if (oh !== 1'b1) begin errors++; $display("FAIL col_pop got %b want 1", oh); end
      if (oh) begin
         e = pop_expected();
         checks++; if (s !== e) begin errors++; $display("FAIL col_lo got %h want %h", s, e); end
      end
      recv_val = 1'b0;
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL col_freed got %b want 1", recv_rdy); end
      for (int c = 0; c < 20; c++) begin
         tick(ih, oh, s);
         if (oh) begin
            e = pop_expected();
            checks++; if (s !== e) begin errors++; $display("FAIL col_drain got %h want %h", s, e); end
         end
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL col_left got %0d want 0", exp_q.size()); end
   endtask

   initial begin
      reset = 1'b0; recv_val = 1'b0; send_rdy = 1'b0; recv_msg = '0;
      test_reset();
      test_single_pair();
      test_full_tile();
      test_backpressure();
      test_random();
      test_full_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
